// File: rtl/wt_mem_req_arbiter.sv
// Round-robin N-port memory request arbiter with per-port outstanding limits and tag-based return routing.
// Defining WT_ARB_PERF_CNT_EN adds per-port saturating grant and stall counters.
module wt_mem_req_arbiter #(
  parameter  int NumPorts       = 3,
  parameter  int DataWidth      = 128,
  parameter  int RtrnWidth      = 128,
  parameter  int TxIdWidth      = 2,
  parameter  int MaxOutstanding = 4,
  localparam int PortW          = (NumPorts > 1) ? $clog2(NumPorts) : 1,
  localparam int TagW           = PortW + TxIdWidth,
  localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumPorts-1:0]           port_req_i,
  output logic [NumPorts-1:0]           port_ack_o,
  input  logic [NumPorts*DataWidth-1:0] port_data_i,
  input  logic [NumPorts*TxIdWidth-1:0] port_txid_i,
  output logic                          mem_req_o,
  input  logic                          mem_ack_i,
  output logic [DataWidth-1:0]          mem_data_o,
  output logic [TagW-1:0]               mem_tag_o,
  input  logic                          mem_rtrn_vld_i,
  input  logic [TagW-1:0]               mem_rtrn_tag_i,
  input  logic [RtrnWidth-1:0]          mem_rtrn_data_i,
  output logic [NumPorts-1:0]           port_rtrn_vld_o,
  output logic [TxIdWidth-1:0]          port_rtrn_txid_o,
  output logic [RtrnWidth-1:0]          port_rtrn_data_o,
  output logic [NumPorts*CntW-1:0]      outstanding_o,
  output logic                          err_orphan_o
`ifdef WT_ARB_PERF_CNT_EN
  ,
  output logic [NumPorts*32-1:0]        perf_grant_cnt_o,
  output logic [NumPorts*32-1:0]        perf_stall_cnt_o
`endif
);

  typedef enum logic {IDLE, REQ} state_e;

  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  state_e               state_q;
  logic [PortW-1:0]     rr_ptr_q;
  logic [PortW-1:0]     grant_q;
  logic [CntW-1:0]      cnt_q [NumPorts];
  logic [NumPorts-1:0]  elig;
  logic [PortW-1:0]     win_hi, win_lo, winner;
  logic                 any_hi, any_lo;
  logic [DataWidth-1:0] sel_data;
  logic [TxIdWidth-1:0] sel_txid;
  logic                 ack_fire;
  logic [PortW-1:0]     rtrn_port;
  logic                 rtrn_hit;

  always_comb begin
    elig = '0;
    for (int p = 0; p < NumPorts; p++) begin
      elig[p] = port_req_i[p] && (cnt_q[p] != CntMax);
    end
  end

  // Two-pass search: ports at or above the pointer first, then wrap to port 0.
  always_comb begin
    any_hi = 1'b0;
    any_lo = 1'b0;
    win_hi = '0;
    win_lo = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (!any_hi && elig[p] && (PortW'(p) >= rr_ptr_q)) begin
        any_hi = 1'b1;
        win_hi = PortW'(p);
      end
      if (!any_lo && elig[p]) begin
        any_lo = 1'b1;
        win_lo = PortW'(p);
      end
    end
    winner = any_hi ? win_hi : win_lo;
  end

  always_comb begin
    sel_data = '0;
    sel_txid = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (winner == PortW'(p)) begin
        sel_data = port_data_i[p*DataWidth +: DataWidth];
        sel_txid = port_txid_i[p*TxIdWidth +: TxIdWidth];
      end
    end
  end

  assign ack_fire = (state_q == REQ) && mem_ack_i;

  always_comb begin
    port_ack_o = '0;
    for (int p = 0; p < NumPorts; p++) begin
      port_ack_o[p] = ack_fire && (grant_q == PortW'(p));
    end
  end

  // Returns to a nonexistent port or to a port with nothing in flight never raise a valid.
  assign rtrn_port = mem_rtrn_tag_i[TagW-1 -: PortW];

  always_comb begin
    port_rtrn_vld_o = '0;
    for (int p = 0; p < NumPorts; p++) begin
      port_rtrn_vld_o[p] = mem_rtrn_vld_i && (rtrn_port == PortW'(p)) && (cnt_q[p] != '0);
    end
  end

  assign rtrn_hit         = |port_rtrn_vld_o;
  assign port_rtrn_txid_o = rtrn_hit ? mem_rtrn_tag_i[TxIdWidth-1:0] : '0;
  assign port_rtrn_data_o = rtrn_hit ? mem_rtrn_data_i : '0;

  always_comb begin
    outstanding_o = '0;
    for (int p = 0; p < NumPorts; p++) begin
      outstanding_o[p*CntW +: CntW] = cnt_q[p];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < NumPorts; p++) begin
        cnt_q[p] <= '0;
      end
      err_orphan_o <= 1'b0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (port_ack_o[p] && !port_rtrn_vld_o[p]) begin
          cnt_q[p] <= cnt_q[p] + CntW'(1);
        end else if (!port_ack_o[p] && port_rtrn_vld_o[p]) begin
          cnt_q[p] <= cnt_q[p] - CntW'(1);
        end
      end
      if (mem_rtrn_vld_i && !rtrn_hit) begin
        err_orphan_o <= 1'b1;
      end
    end
  end

  // Request stage: payload and tag are captured once and held until the memory side accepts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      mem_req_o  <= 1'b0;
      mem_data_o <= '0;
      mem_tag_o  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_lo) begin
            state_q    <= REQ;
            grant_q    <= winner;
            mem_req_o  <= 1'b1;
            mem_data_o <= sel_data;
            mem_tag_o  <= {winner, sel_txid};
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            state_q   <= IDLE;
            mem_req_o <= 1'b0;
            rr_ptr_q  <= (grant_q == PortW'(NumPorts - 1)) ? '0 : grant_q + PortW'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef WT_ARB_PERF_CNT_EN
  localparam logic [31:0] PerfMax = 32'hFFFF_FFFF;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_grant_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (port_ack_o[p] && (perf_grant_cnt_o[p*32 +: 32] != PerfMax)) begin
          perf_grant_cnt_o[p*32 +: 32] <= perf_grant_cnt_o[p*32 +: 32] + 32'd1;
        end
        if (port_req_i[p] && (cnt_q[p] == CntMax) && (perf_stall_cnt_o[p*32 +: 32] != PerfMax)) begin
          perf_stall_cnt_o[p*32 +: 32] <= perf_stall_cnt_o[p*32 +: 32] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Self-checking bench for wt_mem_req_arbiter: directed scenarios plus a randomized run against a reference model.
// Perf counter checks are included when WT_ARB_PERF_CNT_EN is defined.
module tb_wt_mem_req_arbiter;

  localparam int N    = 3;
  localparam int DW   = 128;
  localparam int RW   = 128;
  localparam int TW   = 2;
  localparam int MO   = 4;
  localparam int PW   = 2;
  localparam int TAGW = PW + TW;
  localparam int CW   = 3;

  logic              clk_i;
  logic              rst_ni;
  logic [N-1:0]      port_req_i;
  logic [N-1:0]      port_ack_o;
  logic [N*DW-1:0]   port_data_i;
  logic [N*TW-1:0]   port_txid_i;
  logic              mem_req_o;
  logic              mem_ack_i;
  logic [DW-1:0]     mem_data_o;
  logic [TAGW-1:0]   mem_tag_o;
  logic              mem_rtrn_vld_i;
  logic [TAGW-1:0]   mem_rtrn_tag_i;
  logic [RW-1:0]     mem_rtrn_data_i;
  logic [N-1:0]      port_rtrn_vld_o;
  logic [TW-1:0]     port_rtrn_txid_o;
  logic [RW-1:0]     port_rtrn_data_o;
  logic [N*CW-1:0]   outstanding_o;
  logic              err_orphan_o;
`ifdef WT_ARB_PERF_CNT_EN
  logic [N*32-1:0]   perf_grant_cnt_o;
  logic [N*32-1:0]   perf_stall_cnt_o;
`endif

  int compared;
  int mismatched;

  wt_mem_req_arbiter #(
    .NumPorts(N), .DataWidth(DW), .RtrnWidth(RW), .TxIdWidth(TW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .port_req_i(port_req_i), .port_ack_o(port_ack_o),
    .port_data_i(port_data_i), .port_txid_i(port_txid_i),
    .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i),
    .mem_data_o(mem_data_o), .mem_tag_o(mem_tag_o),
    .mem_rtrn_vld_i(mem_rtrn_vld_i), .mem_rtrn_tag_i(mem_rtrn_tag_i),
    .mem_rtrn_data_i(mem_rtrn_data_i),
    .port_rtrn_vld_o(port_rtrn_vld_o), .port_rtrn_txid_o(port_rtrn_txid_o),
    .port_rtrn_data_o(port_rtrn_data_o),
    .outstanding_o(outstanding_o), .err_orphan_o(err_orphan_o)
`ifdef WT_ARB_PERF_CNT_EN
    , .perf_grant_cnt_o(perf_grant_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic apply_reset();
    rst_ni          = 1'b0;
    port_req_i      = '0;
    port_data_i     = '0;
    port_txid_i     = '0;
    mem_ack_i       = 1'b0;
    mem_rtrn_vld_i  = 1'b0;
    mem_rtrn_tag_i  = '0;
    mem_rtrn_data_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic set_req(input int p, input logic [TW-1:0] txid, input logic [DW-1:0] data);
    port_req_i[p]           = 1'b1;
    port_txid_i[p*TW +: TW] = txid;
    port_data_i[p*DW +: DW] = data;
  endtask

  // Waits (bounded) for mem_req_o, holds off ack for 'delay' cycles, then acks once.
  task automatic serve_one(input int delay, output logic [TAGW-1:0] tag, output logic [DW-1:0] data,
                           output logic [N-1:0] acks, output int waits, output bit ok);
    ok    = 1'b0;
    waits = 0;
    tag   = '0;
    data  = '0;
    acks  = '0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk_i);
      waits++;
      ok = (mem_req_o === 1'b1);
    end
    if (ok) begin
      tag  = mem_tag_o;
      data = mem_data_o;
      repeat (delay) @(negedge clk_i);
      mem_ack_i = 1'b1;
      #1 acks = port_ack_o;
      @(posedge clk_i);
      #1 mem_ack_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    rst_ni = 1'b0;
    #3;
    compared++;
    if ({mem_req_o, port_ack_o, port_rtrn_vld_o, outstanding_o, err_orphan_o, mem_tag_o, port_rtrn_txid_o} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got req=%b ack=%b rv=%b out=%h err=%b tag=%h, expected all 0",
               mem_req_o, port_ack_o, port_rtrn_vld_o, outstanding_o, err_orphan_o, mem_tag_o);
    end
    compared++;
    if (mem_data_o !== '0 || port_rtrn_data_o !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_data: got mem_data=%h rtrn_data=%h, expected 0", mem_data_o, port_rtrn_data_o);
    end
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    compared++;
    if (mem_req_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_idle_req: got %b expected 0", mem_req_o);
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0]   d [N];
    logic [TAGW-1:0] tag, exp_tag;
    logic [DW-1:0]   data;
    logic [N-1:0]    acks, exp_ack;
    int              waits;
    bit              ok;
    apply_reset();
    for (int p = 0; p < N; p++) begin
      d[p] = rand_data();
      set_req(p, '0, d[p]);
    end
    for (int k = 0; k < N; k++) begin
      serve_one(1, tag, data, acks, waits, ok);
      exp_tag = {PW'(k), TW'(0)};
      exp_ack = '0;
      exp_ack[k] = 1'b1;
      compared++;
      if (!ok || tag !== exp_tag) begin
        mismatched++;
        $display("[TB] FAIL rr_tag[%0d]: got %h (seen=%0b) expected %h", k, tag, ok, exp_tag);
      end
      compared++;
      if (acks !== exp_ack) begin
        mismatched++;
        $display("[TB] FAIL rr_ack[%0d]: got %b expected %b", k, acks, exp_ack);
      end
      compared++;
      if (data !== d[k]) begin
        mismatched++;
        $display("[TB] FAIL rr_data[%0d]: got %h expected %h", k, data, d[k]);
      end
      port_req_i[k] = 1'b0;
    end
    @(negedge clk_i);
    compared++;
    if (outstanding_o !== 9'o111) begin
      mismatched++;
      $display("[TB] FAIL rr_outstanding: got %o expected 111", outstanding_o);
    end
  endtask

  task automatic test_outstanding_limit();
    logic [TAGW-1:0] tag;
    logic [DW-1:0]   data;
    logic [N-1:0]    acks;
    logic [RW-1:0]   rd;
    int              waits;
    bit              ok;
    apply_reset();
    for (int k = 0; k < MO; k++) begin
      set_req(1, TW'(k), rand_data());
      serve_one(0, tag, data, acks, waits, ok);
      compared++;
      if (!ok || tag !== {2'd1, TW'(k)}) begin
        mismatched++;
        $display("[TB] FAIL limit_fill[%0d]: got %h expected %h", k, tag, {2'd1, TW'(k)});
      end
    end
    set_req(1, '0, rand_data());
    set_req(2, '0, rand_data());
    serve_one(0, tag, data, acks, waits, ok);
    compared++;
    if (!ok || tag !== 4'h8 || acks !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL limit_other_port: got tag=%h ack=%b expected tag=8 ack=100", tag, acks);
    end
    port_req_i[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      compared++;
      if (mem_req_o !== 1'b0 || outstanding_o[5:3] !== 3'd4) begin
        mismatched++;
        $display("[TB] FAIL limit_blocked[%0d]: got req=%b cnt1=%0d expected req=0 cnt1=4", c, mem_req_o, outstanding_o[5:3]);
      end
    end
    @(posedge clk_i);
    #1;
    rd              = rand_data();
    mem_rtrn_vld_i  = 1'b1;
    mem_rtrn_tag_i  = 4'h5;
    mem_rtrn_data_i = rd;
    #2;
    compared++;
    if (port_rtrn_vld_o !== 3'b010 || port_rtrn_txid_o !== 2'd1 || port_rtrn_data_o !== rd) begin
      mismatched++;
      $display("[TB] FAIL limit_return: got vld=%b txid=%0d data=%h expected vld=010 txid=1 data=%h",
               port_rtrn_vld_o, port_rtrn_txid_o, port_rtrn_data_o, rd);
    end
    @(posedge clk_i);
    #1 mem_rtrn_vld_i = 1'b0;
    #2;
    compared++;
    if (outstanding_o[5:3] !== 3'd3) begin
      mismatched++;
      $display("[TB] FAIL limit_cnt_after_return: got %0d expected 3", outstanding_o[5:3]);
    end
    serve_one(0, tag, data, acks, waits, ok);
    compared++;
    if (!ok || tag !== 4'h4 || waits !== 2) begin
      mismatched++;
      $display("[TB] FAIL limit_regrant: got tag=%h after %0d cycles expected tag=4 after 2", tag, waits);
    end
    port_req_i = '0;
  endtask

  task automatic test_ack_stall();
    logic [DW-1:0]   d0;
    logic [TAGW-1:0] tag;
    logic [DW-1:0]   data;
    logic [N-1:0]    acks;
    int              waits;
    bit              ok;
    apply_reset();
    d0 = rand_data();
    set_req(0, 2'd1, d0);
    set_req(2, 2'd2, rand_data());
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk_i);
      ok = (mem_req_o === 1'b1);
    end
    compared++;
    if (!ok || mem_tag_o !== 4'h1 || mem_data_o !== d0) begin
      mismatched++;
      $display("[TB] FAIL stall_first: got req=%b tag=%h expected req=1 tag=1", mem_req_o, mem_tag_o);
    end
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk_i);
      compared++;
      if (mem_req_o !== 1'b1 || mem_tag_o !== 4'h1 || mem_data_o !== d0 || port_ack_o !== 3'b000) begin
        mismatched++;
        $display("[TB] FAIL stall_hold[%0d]: got req=%b tag=%h ack=%b expected req=1 tag=1 ack=000",
                 c, mem_req_o, mem_tag_o, port_ack_o);
      end
    end
    @(negedge clk_i);
    mem_ack_i = 1'b1;
    #1;
    compared++;
    if (port_ack_o !== 3'b001) begin
      mismatched++;
      $display("[TB] FAIL stall_ack: got %b expected 001", port_ack_o);
    end
    @(posedge clk_i);
    #1;
    mem_ack_i     = 1'b0;
    port_req_i[0] = 1'b0;
    serve_one(0, tag, data, acks, waits, ok);
    compared++;
    if (!ok || tag !== 4'hA || acks !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL stall_next: got tag=%h ack=%b expected tag=a ack=100", tag, acks);
    end
    port_req_i = '0;
  endtask

  task automatic test_orphan();
    apply_reset();
    mem_rtrn_vld_i  = 1'b1;
    mem_rtrn_tag_i  = 4'h8;
    mem_rtrn_data_i = rand_data();
    #2;
    compared++;
    if (port_rtrn_vld_o !== 3'b000 || err_orphan_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL orphan_zero_cnt: got vld=%b err=%b expected vld=000 err=0", port_rtrn_vld_o, err_orphan_o);
    end
    @(posedge clk_i);
    #1 mem_rtrn_tag_i = 4'hC;
    #2;
    compared++;
    if (port_rtrn_vld_o !== 3'b000 || err_orphan_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL orphan_bad_port: got vld=%b err=%b expected vld=000 err=1", port_rtrn_vld_o, err_orphan_o);
    end
    @(posedge clk_i);
    #1 mem_rtrn_vld_i = 1'b0;
    repeat (3) @(negedge clk_i);
    compared++;
    if (err_orphan_o !== 1'b1 || outstanding_o !== '0) begin
      mismatched++;
      $display("[TB] FAIL orphan_sticky: got err=%b out=%o expected err=1 out=0", err_orphan_o, outstanding_o);
    end
  endtask

  task automatic test_simultaneous();
    logic [TAGW-1:0] tag;
    logic [DW-1:0]   data;
    logic [N-1:0]    acks;
    logic [RW-1:0]   rd;
    int              waits;
    bit              ok;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      set_req(0, TW'(k), rand_data());
      serve_one(0, tag, data, acks, waits, ok);
    end
    set_req(0, 2'd2, rand_data());
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk_i);
      ok = (mem_req_o === 1'b1);
    end
    rd              = rand_data();
    mem_ack_i       = 1'b1;
    mem_rtrn_vld_i  = 1'b1;
    mem_rtrn_tag_i  = 4'h0;
    mem_rtrn_data_i = rd;
    #1;
    compared++;
    if (!ok || port_ack_o !== 3'b001 || port_rtrn_vld_o !== 3'b001 || outstanding_o[2:0] !== 3'd2) begin
      mismatched++;
      $display("[TB] FAIL simul_pulses: got ack=%b rv=%b cnt0=%0d expected ack=001 rv=001 cnt0=2",
               port_ack_o, port_rtrn_vld_o, outstanding_o[2:0]);
    end
    @(posedge clk_i);
    #1;
    mem_ack_i      = 1'b0;
    mem_rtrn_vld_i = 1'b0;
    port_req_i     = '0;
    #2;
    compared++;
    if (outstanding_o[2:0] !== 3'd2 || err_orphan_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL simul_cnt: got cnt0=%0d err=%b expected cnt0=2 err=0", outstanding_o[2:0], err_orphan_o);
    end
  endtask

  task automatic test_reset_mid_req();
    logic [TAGW-1:0] tag;
    logic [DW-1:0]   data, d0;
    logic [N-1:0]    acks;
    int              waits;
    bit              ok;
    apply_reset();
    set_req(1, 2'd0, rand_data());
    serve_one(0, tag, data, acks, waits, ok);
    set_req(1, 2'd1, rand_data());
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk_i);
      ok = (mem_req_o === 1'b1);
    end
    rst_ni = 1'b0;
    #1;
    compared++;
    if (!ok || mem_req_o !== 1'b0 || outstanding_o !== '0 || port_ack_o !== '0) begin
      mismatched++;
      $display("[TB] FAIL midreq_reset: got req=%b out=%o ack=%b (req seen=%0b) expected 0/0/0",
               mem_req_o, outstanding_o, port_ack_o, ok);
    end
`ifdef WT_ARB_PERF_CNT_EN
    compared++;
    if (perf_grant_cnt_o !== '0 || perf_stall_cnt_o !== '0) begin
      mismatched++;
      $display("[TB] FAIL midreq_perf: got grant=%h stall=%h expected 0", perf_grant_cnt_o, perf_stall_cnt_o);
    end
`endif
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    d0 = rand_data();
    set_req(0, 2'd3, d0);
    set_req(2, 2'd1, rand_data());
    serve_one(0, tag, data, acks, waits, ok);
    compared++;
    if (!ok || tag !== 4'h3 || data !== d0) begin
      mismatched++;
      $display("[TB] FAIL midreq_first_winner: got tag=%h expected 3", tag);
    end
    port_req_i = '0;
  endtask

  task automatic test_random(input int cycles);
    bit              busy, orphan, hit;
    int              gp, rp, drop;
    logic [TW-1:0]   gt;
    logic [DW-1:0]   gd;
    logic [RW-1:0]   rd;
    int              cnt [N];
    int              rr;
    logic [TAGW-1:0] inflight [$];
    logic [N-1:0]    exp_ack, exp_rv;
    logic [N*CW-1:0] exp_out;
`ifdef WT_ARB_PERF_CNT_EN
    int              pg [N];
    int              ps [N];
`endif
    apply_reset();
    busy = 1'b0; orphan = 1'b0; rr = 0; gp = 0; gt = '0; gd = '0; rd = '0;
    inflight.delete();
    for (int p = 0; p < N; p++) begin
      cnt[p] = 0;
`ifdef WT_ARB_PERF_CNT_EN
      pg[p] = 0;
      ps[p] = 0;
`endif
    end
    for (int c = 0; c < cycles; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!port_req_i[p] && $urandom_range(0, 2) == 0) set_req(p, TW'($urandom()), rand_data());
      end
      mem_ack_i      = busy && ($urandom_range(0, 1) == 1);
      mem_rtrn_vld_i = 1'b0;
      if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
        int k;
        k               = $urandom_range(0, inflight.size() - 1);
        rd              = rand_data();
        mem_rtrn_tag_i  = inflight[k];
        mem_rtrn_data_i = rd;
        mem_rtrn_vld_i  = 1'b1;
        inflight.delete(k);
      end else if ($urandom_range(0, 49) == 0) begin
        mem_rtrn_tag_i = {2'd3, TW'($urandom())};
        mem_rtrn_vld_i = 1'b1;
      end
      #3;
      rp  = int'(mem_rtrn_tag_i[TAGW-1 -: PW]);
      hit = mem_rtrn_vld_i && (rp < N) && (cnt[rp] > 0);
      exp_ack = '0;
      if (busy && mem_ack_i) exp_ack[gp] = 1'b1;
      exp_rv = '0;
      if (hit) exp_rv[rp] = 1'b1;
      for (int p = 0; p < N; p++) exp_out[p*CW +: CW] = CW'(cnt[p]);

      compared++;
      if (mem_req_o !== busy) begin
        mismatched++;
        $display("[TB] FAIL rand_req[%0d]: got %b expected %b", c, mem_req_o, busy);
      end
      if (busy) begin
        compared++;
        if (mem_tag_o !== {PW'(gp), gt} || mem_data_o !== gd) begin
          mismatched++;
          $display("[TB] FAIL rand_payload[%0d]: got tag=%h expected tag=%h", c, mem_tag_o, {PW'(gp), gt});
        end
      end
      compared++;
      if (port_ack_o !== exp_ack) begin
        mismatched++;
        $display("[TB] FAIL rand_ack[%0d]: got %b expected %b", c, port_ack_o, exp_ack);
      end
      compared++;
      if (port_rtrn_vld_o !== exp_rv) begin
        mismatched++;
        $display("[TB] FAIL rand_rtrn_vld[%0d]: got %b expected %b", c, port_rtrn_vld_o, exp_rv);
      end
      if (hit) begin
        compared++;
        if (port_rtrn_txid_o !== mem_rtrn_tag_i[TW-1:0] || port_rtrn_data_o !== rd) begin
          mismatched++;
          $display("[TB] FAIL rand_rtrn_payload[%0d]: got txid=%0d expected %0d", c, port_rtrn_txid_o, mem_rtrn_tag_i[TW-1:0]);
        end
      end
      compared++;
      if (outstanding_o !== exp_out) begin
        mismatched++;
        $display("[TB] FAIL rand_outstanding[%0d]: got %o expected %o", c, outstanding_o, exp_out);
      end
      compared++;
      if (err_orphan_o !== orphan) begin
        mismatched++;
        $display("[TB] FAIL rand_orphan[%0d]: got %b expected %b", c, err_orphan_o, orphan);
      end

`ifdef WT_ARB_PERF_CNT_EN
      for (int p = 0; p < N; p++) begin
        if (port_req_i[p] && cnt[p] == MO) ps[p]++;
      end
`endif
      drop = -1;
      if (busy && mem_ack_i) begin
        cnt[gp]++;
        rr   = (gp + 1) % N;
        busy = 1'b0;
        drop = gp;
        inflight.push_back({PW'(gp), gt});
`ifdef WT_ARB_PERF_CNT_EN
        pg[gp]++;
`endif
      end else if (!busy) begin
        for (int i = 0; i < N && !busy; i++) begin
          int q;
          q = (rr + i) % N;
          if (port_req_i[q] && cnt[q] < MO) begin
            busy = 1'b1;
            gp   = q;
            gt   = port_txid_i[q*TW +: TW];
            gd   = port_data_i[q*DW +: DW];
          end
        end
      end
      if (hit) cnt[rp]--;
      else if (mem_rtrn_vld_i) orphan = 1'b1;

      @(posedge clk_i);
      #1;
      if (drop >= 0) port_req_i[drop] = 1'b0;
    end
`ifdef WT_ARB_PERF_CNT_EN
    for (int p = 0; p < N; p++) begin
      compared++;
      if (perf_grant_cnt_o[p*32 +: 32] !== 32'(pg[p]) || perf_stall_cnt_o[p*32 +: 32] !== 32'(ps[p])) begin
        mismatched++;
        $display("[TB] FAIL rand_perf[%0d]: got grant=%0d stall=%0d expected grant=%0d stall=%0d",
                 p, perf_grant_cnt_o[p*32 +: 32], perf_stall_cnt_o[p*32 +: 32], pg[p], ps[p]);
      end
    end
`endif
    port_req_i     = '0;
    mem_ack_i      = 1'b0;
    mem_rtrn_vld_i = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_round_robin();
    test_outstanding_limit();
    test_ack_stall();
    test_orphan();
    test_simultaneous();
    test_reset_mid_req();
    test_random(600);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
